exe_addsub_pipe: RTL and testbench
==================================

Name: exe_addsub_pipe

Overview:
- Parametrised, fully pipelined integer add/subtract/compare unit for the EXE stage.
- Successor to the fixed 32-bit, fixed two-cycle adder.
- Adds configurable width and latency, back-to-back issue, a per-stage valid pipeline, overflow/carry flags, optional saturation, an illegal-op flag and a synchronous flush (kill).
- Sits between the issue/decode logic and the writeback mux; every accepted op produces exactly one valid pulse unless killed.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).
- LATENCY, 2, cycles from accepted start to valid (>=1).
- SAT, 0, 1 = signed ADD/SUB saturate to max/min on overflow; 0 = wrap.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  issue strobe; op/a/b sampled on the same edge.
- op  input  3  operation code.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- kill  input  1  synchronous flush of all in-flight ops.
- valid  output  1  one-cycle pulse per completed op.
- result  output  WIDTH  result, meaningful only while valid=1.
- ovf  output  1  signed overflow (ADD/SUB), qualified by valid.
- carry  output  1  unsigned carry-out (ADD) / no-borrow (SUB), qualified by valid.
- illegal  output  1  op code was not 0..3, qualified by valid.
- busy  output  1  one or more ops in flight (combinational OR of stage valid bits).

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset: on rising clk with rst_n=0, all stage valid bits, data stages, valid, result, ovf, carry and illegal go to 0; busy=0 in the following cycle. Reset mid-operation discards all in-flight ops; no valid pulse is produced for them.
- Op codes:
  - 0 ADD: a+b.
  - 1 SUB: b-a (operand order is fixed).
  - 2 SLT: result = {0..,1} if signed(b) < signed(a), else 0.
  - 3 SLTU: same comparison, unsigned.
  - 4..7: result=0, illegal=1, ovf=carry=0.
- Arithmetic: computed combinationally at stage 0 in WIDTH+1 bits.
  - carry = bit WIDTH of the sum (ADD), or of b + ~a + 1 (SUB).
  - ovf = sign-mismatch rule on the operand and result MSBs.
  - SAT=1 with ovf=1: result = 0111..1 if the true result is positive, 1000..0 if negative; ovf is still reported.
  - SLT, SLTU and illegal ops always report ovf=carry=0.
- Pipeline:
  - LATENCY register stages, each holding {v, result, ovf, carry, illegal}; stage 0 loads on start; the last stage drives the outputs directly.
  - Timing: start=1 at edge k gives valid=1 during the cycle after edge k+LATENCY-1, i.e. exactly LATENCY cycles after the issue cycle.
  - Throughput: one op per cycle; start may be held high for consecutive cycles, giving consecutive valid pulses in issue order. There is no back-pressure; the consumer must accept every valid.
- Kill: kill=1 at an edge clears every stage v bit, so valid=0 from the next cycle. A start coinciding with kill is dropped (kill wins). Data registers may retain stale values.
- Outputs while valid=0: result/flags hold their last value; consumers must ignore them.
- busy = OR of all stage v bits.

Decomposition:
- Shared package exe_pkg: op code constants (OP_ADD=0, OP_SUB=1, OP_SLT=2, OP_SLTU=3), OP_W=3, and the stage payload struct/width constant.
- One sub-module, exe_addsub_core: combinational WIDTH-parametrised compute (result, ovf, carry, illegal, saturation).
- Top level holds only the valid/data shift pipeline, kill and reset.

Test Plan:
- Single ADD, WIDTH=32, LATENCY=2: start with a=5, b=7 in cycle 0 -> valid only in cycle 2, result=12, ovf=0, carry=0, busy=1 in cycles 1-2.
- Back-to-back issue, 3 cycles: SUB(a=3,b=10), ADD(a=FFFFFFFF,b=1), SLT(a=1,b=FFFFFFFF) -> valid in cycles 2,3,4; results 7; 0 with carry=1; 1.
- Overflow, SAT=0 then SAT=1: ADD a=7FFFFFFF, b=1 -> SAT=0 gives 80000000 with ovf=1; SAT=1 gives 7FFFFFFF with ovf=1.
- Illegal op=5 -> valid after LATENCY, result=0, illegal=1, ovf=0, carry=0.
- Kill: issue ops in cycles 0 and 1, kill=1 in cycle 1 -> no valid in cycles 2-3, busy=0 from cycle 2; an op issued in cycle 2 gives valid in cycle 4.
- Reset mid-flight and LATENCY=1/WIDTH=8: rst_n=0 one cycle after start -> no valid, all outputs 0. With LATENCY=1, WIDTH=8: SLTU a=80, b=7F -> valid the next cycle, result=01.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared op codes and stage payload layout for the EXE add/sub/compare unit.
// Constants and types only; no latency or flow-control behaviour of its own.
package exe_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
    localparam logic [OP_W-1:0] OP_SLT  = 3'd2;
    localparam logic [OP_W-1:0] OP_SLTU = 3'd3;

    // Flag part of each pipeline stage; the result word is stored alongside it.
    typedef struct packed {
        logic ovf;
        logic carry;
        logic illegal;
    } flags_t;

    localparam int FLAGS_W = $bits(flags_t);

endpackage

// File: rtl/exe_addsub_core.sv
// Combinational add/sub/compare with overflow, carry, saturation and illegal-op detection.
// Zero latency; no backpressure (pure function of op/a/b).
module exe_addsub_core
    import exe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SAT   = 0
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             carry,
    output logic             illegal
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           true_neg;

    assign sum  = {1'b0, a} + {1'b0, b};
    // SUB is b - a, formed as b + ~a + 1 so bit WIDTH is the no-borrow flag.
    assign diff = {1'b0, b} + {1'b0, ~a} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        result   = '0;
        ovf      = 1'b0;
        carry    = 1'b0;
        illegal  = 1'b0;
        true_neg = 1'b0;
        case (op)
            OP_ADD: begin
                result   = sum[WIDTH-1:0];
                carry    = sum[WIDTH];
                ovf      = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
                true_neg = a[MSB];
            end
            OP_SUB: begin
                result   = diff[WIDTH-1:0];
                carry    = diff[WIDTH];
                ovf      = (a[MSB] != b[MSB]) && (diff[MSB] != b[MSB]);
                true_neg = b[MSB];
            end
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(b) < $signed(a))};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, (b < a)};
            default: illegal = 1'b1;
        endcase
        // On overflow the true result's sign is the sign of the dominant operand.
        if (SAT != 0 && ovf) begin
            result = true_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/exe_addsub_pipe.sv
// Pipelined EXE add/sub/compare: LATENCY register stages after the compute core.
// Valid appears LATENCY cycles after start; no backpressure, kill flushes all stages.
module exe_addsub_pipe
    import exe_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2,
    parameter int SAT     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             carry,
    output logic             illegal,
    output logic             busy
);

    logic [WIDTH-1:0]   c_res;
    logic               c_ovf;
    logic               c_carry;
    logic               c_illegal;
    flags_t             flg_d;
    flags_t             flg_out;

    logic [LATENCY-1:0] v_q;
    logic [WIDTH-1:0]   res_q [LATENCY];
    logic [FLAGS_W-1:0] flg_q [LATENCY];

    exe_addsub_core #(
        .WIDTH (WIDTH),
        .SAT   (SAT)
    ) u_core (
        .op      (op),
        .a       (a),
        .b       (b),
        .result  (c_res),
        .ovf     (c_ovf),
        .carry   (c_carry),
        .illegal (c_illegal)
    );

    assign flg_d = '{ovf: c_ovf, carry: c_carry, illegal: c_illegal};

    // Data only advances alongside a live valid bit, so outputs hold between pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                res_q[i] <= '0;
                flg_q[i] <= '0;
            end
        end else begin
            v_q[0] <= start & ~kill;
            if (start && !kill) begin
                res_q[0] <= c_res;
                flg_q[0] <= flg_d;
            end
            for (int i = 1; i < LATENCY; i++) begin
                v_q[i] <= v_q[i-1] & ~kill;
                if (v_q[i-1] && !kill) begin
                    res_q[i] <= res_q[i-1];
                    flg_q[i] <= flg_q[i-1];
                end
            end
        end
    end

    assign flg_out = flags_t'(flg_q[LATENCY-1]);
    assign valid   = v_q[LATENCY-1];
    assign result  = res_q[LATENCY-1];
    assign ovf     = flg_out.ovf;
    assign carry   = flg_out.carry;
    assign illegal = flg_out.illegal;
    assign busy    = |v_q;

endmodule

// File: tb/tb_exe_addsub_pipe.sv
// Directed bench for exe_addsub_pipe: wrap, saturating and 8-bit single-stage instances.
module tb_exe_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, kill;
    logic [2:0]  op;
    logic [31:0] a, b;

    logic        valid, ovf, carry, illegal, busy;
    logic [31:0] result;
    logic        s_valid, s_ovf, s_carry, s_illegal, s_busy;
    logic [31:0] s_result;

    logic        w_start, w_kill;
    logic [2:0]  w_op;
    logic [7:0]  w_a, w_b;
    logic        w_valid, w_ovf, w_carry, w_illegal, w_busy;
    logic [7:0]  w_result;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    exe_addsub_pipe #(.WIDTH(32), .LATENCY(2), .SAT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .kill(kill),
        .valid(valid), .result(result), .ovf(ovf), .carry(carry),
        .illegal(illegal), .busy(busy)
    );

    exe_addsub_pipe #(.WIDTH(32), .LATENCY(2), .SAT(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .kill(kill),
        .valid(s_valid), .result(s_result), .ovf(s_ovf), .carry(s_carry),
        .illegal(s_illegal), .busy(s_busy)
    );

    exe_addsub_pipe #(.WIDTH(8), .LATENCY(1), .SAT(0)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(w_start), .op(w_op), .a(w_a), .b(w_b), .kill(w_kill),
        .valid(w_valid), .result(w_result), .ovf(w_ovf), .carry(w_carry),
        .illegal(w_illegal), .busy(w_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = 3'd0; a = '0; b = '0;
        w_start = 1'b0; w_kill = 1'b0; w_op = 3'd0; w_a = '0; w_b = '0;
        step(); step();
        chk("rst_valid",   {31'd0, valid},   32'd0);
        chk("rst_result",  result,           32'd0);
        chk("rst_flags",   {29'd0, ovf, carry, illegal}, 32'd0);
        chk("rst_busy",    {31'd0, busy},    32'd0);
        chk("rst_w8",      {23'd0, w_valid, w_result}, 32'd0);
        rst_n = 1'b1;

        // Single ADD 5+7
        start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd7;
        step();
        start = 1'b0;
        chk("add_c1_valid", {31'd0, valid}, 32'd0);
        chk("add_c1_busy",  {31'd0, busy},  32'd1);
        step();
        chk("add_c2_valid", {31'd0, valid}, 32'd1);
        chk("add_c2_result", result, 32'd12);
        chk("add_c2_flags", {30'd0, ovf, carry}, 32'd0);
        chk("add_c2_busy",  {31'd0, busy},  32'd1);
        step();
        chk("add_c3_valid", {31'd0, valid}, 32'd0);
        chk("add_c3_busy",  {31'd0, busy},  32'd0);
        chk("add_hold",     result, 32'd12);

        // Back-to-back SUB, ADD, SLT
        start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd10;
        step();
        op = 3'd0; a = 32'hFFFF_FFFF; b = 32'd1;
        chk("b2b_c1_valid", {31'd0, valid}, 32'd0);
        step();
        op = 3'd2; a = 32'd1; b = 32'hFFFF_FFFF;
        chk("b2b_sub_valid", {31'd0, valid}, 32'd1);
        chk("b2b_sub_result", result, 32'd7);
        chk("b2b_sub_carry", {31'd0, carry}, 32'd1);
        step();
        start = 1'b0;
        chk("b2b_add_valid", {31'd0, valid}, 32'd1);
        chk("b2b_add_result", result, 32'd0);
        chk("b2b_add_cf", {30'd0, ovf, carry}, 32'd1);
        step();
        chk("b2b_slt_valid", {31'd0, valid}, 32'd1);
        chk("b2b_slt_result", result, 32'd1);
        chk("b2b_slt_cf", {30'd0, ovf, carry}, 32'd0);
        step();
        chk("b2b_c5_valid", {31'd0, valid}, 32'd0);

        // Positive overflow, then negative overflow on SUB
        start = 1'b1; op = 3'd0; a = 32'h7FFF_FFFF; b = 32'd1;
        step();
        op = 3'd1; a = 32'd1; b = 32'h8000_0000;
        step();
        start = 1'b0;
        chk("ovf_wrap_result", result, 32'h8000_0000);
        chk("ovf_wrap_ovf", {31'd0, ovf}, 32'd1);
        chk("ovf_sat_result", s_result, 32'h7FFF_FFFF);
        chk("ovf_sat_ovf", {31'd0, s_ovf}, 32'd1);
        step();
        chk("sub_wrap_result", result, 32'h7FFF_FFFF);
        chk("sub_wrap_ovf", {31'd0, ovf}, 32'd1);
        chk("sub_sat_result", s_result, 32'h8000_0000);
        chk("sub_sat_valid", {31'd0, s_valid}, 32'd1);
        step();

        // Illegal op
        start = 1'b1; op = 3'd5; a = 32'd5; b = 32'd7;
        step();
        start = 1'b0;
        chk("ill_c1_valid", {31'd0, valid}, 32'd0);
        step();
        chk("ill_valid", {31'd0, valid}, 32'd1);
        chk("ill_result", result, 32'd0);
        chk("ill_flags", {29'd0, ovf, carry, illegal}, 32'd1);
        step();

        // Kill: ops in cycles 0 and 1, kill in cycle 1, new op in cycle 2
        start = 1'b1; op = 3'd0; a = 32'd1; b = 32'd2;
        step();
        a = 32'd3; b = 32'd4; kill = 1'b1;
        step();
        kill = 1'b0; a = 32'd10; b = 32'd20;
        chk("kill_c2_valid", {31'd0, valid}, 32'd0);
        chk("kill_c2_busy",  {31'd0, busy},  32'd0);
        step();
        start = 1'b0;
        chk("kill_c3_valid", {31'd0, valid}, 32'd0);
        chk("kill_c3_busy",  {31'd0, busy},  32'd1);
        step();
        chk("kill_c4_valid", {31'd0, valid}, 32'd1);
        chk("kill_c4_result", result, 32'd30);
        step();

        // Reset one cycle after start
        start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd7;
        step();
        start = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rstmid_valid",  {31'd0, valid}, 32'd0);
        chk("rstmid_result", result, 32'd0);
        chk("rstmid_busy",   {31'd0, busy},  32'd0);
        step();
        chk("rstmid_c3_valid", {31'd0, valid}, 32'd0);

        // WIDTH=8, LATENCY=1: SLTU, SLT, ADD with carry, back to back
        w_start = 1'b1; w_op = 3'd3; w_a = 8'h80; w_b = 8'h7F;
        step();
        w_op = 3'd2;
        chk("w8_sltu_valid",  {31'd0, w_valid}, 32'd1);
        chk("w8_sltu_result", {24'd0, w_result}, 32'h01);
        step();
        w_op = 3'd0; w_a = 8'hFF; w_b = 8'h01;
        chk("w8_slt_result", {24'd0, w_result}, 32'h00);
        step();
        w_start = 1'b0;
        chk("w8_add_result", {24'd0, w_result}, 32'h00);
        chk("w8_add_cf", {30'd0, w_ovf, w_carry}, 32'd1);
        step();
        chk("w8_idle_valid", {31'd0, w_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
